// File: rtl/sysid_checker.sv
// Reads the system ID and timestamp words over Avalon-MM and compares them against
// build-time constants, retrying timed-out reads before flagging a timeout error.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1489607473,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
    parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  retry_count
);

    localparam int unsigned TCNT_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK,
        FAIL
    } state_t;

    state_t              state, state_nx;
    logic [TCNT_W-1:0]   tcnt, tcnt_nx;
    logic [1:0]          retry_nx;
    logic [DATA_W-1:0]   id_nx, ts_nx;
    logic                pass_nx, terr_nx;
    logic                busy_nx, done_nx, read_nx, addr_nx;
    logic                in_req, in_ts, accepted, got_data, timeout_hit;

    // Next-state, result updates and registered output values
    always_comb begin
        state_nx    = state;
        tcnt_nx     = tcnt;
        retry_nx    = retry_count;
        id_nx       = id_value;
        ts_nx       = ts_value;
        pass_nx     = pass;
        terr_nx     = timeout_err;
        in_req      = (state == ID_REQ) || (state == TS_REQ);
        in_ts       = (state == TS_REQ) || (state == TS_WAIT);
        accepted    = in_req && !avm_waitrequest;
        got_data    = in_req ? (accepted && avm_readdatavalid) : avm_readdatavalid;
        timeout_hit = ({1'b0, tcnt} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ID_REQ;
                    tcnt_nx  = '0;
                    retry_nx = '0;
                    id_nx    = '0;
                    ts_nx    = '0;
                    pass_nx  = 1'b0;
                    terr_nx  = 1'b0;
                end
            end
            ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
                tcnt_nx = TCNT_W'(tcnt + 8'd1);
                // Data on the final cycle still counts; only a dataless cycle can time out
                if (got_data) begin
                    if (in_ts) begin
                        ts_nx    = avm_readdata;
                        pass_nx  = (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
                        state_nx = CHECK;
                    end else begin
                        id_nx    = avm_readdata;
                        tcnt_nx  = '0;
                        state_nx = TS_REQ;
                    end
                end else if (timeout_hit) begin
                    if (retry_count < MAX_RETRIES) begin
                        retry_nx = 2'(retry_count + 2'd1);
                        tcnt_nx  = '0;
                        state_nx = in_ts ? TS_REQ : ID_REQ;
                    end else begin
                        terr_nx  = 1'b1;
                        pass_nx  = 1'b0;
                        state_nx = FAIL;
                    end
                end else if (accepted) begin
                    state_nx = in_ts ? TS_WAIT : ID_WAIT;
                end
            end
            CHECK, FAIL: state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase

        busy_nx = (state_nx == ID_REQ) || (state_nx == ID_WAIT) ||
                  (state_nx == TS_REQ) || (state_nx == TS_WAIT);
        done_nx = (state_nx == CHECK) || (state_nx == FAIL);
        read_nx = (state_nx == ID_REQ) || (state_nx == TS_REQ);
        addr_nx = (state_nx == TS_REQ) || (state_nx == TS_WAIT);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            retry_count <= '0;
            id_value    <= '0;
            ts_value    <= '0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            retry_count <= retry_nx;
            id_value    <= id_nx;
            ts_value    <= ts_nx;
            pass        <= pass_nx;
            timeout_err <= terr_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            avm_read    <= read_nx;
            avm_address <= addr_nx;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized bench for sysid_checker: a planned Avalon slave plus a read-attempt level
// outcome model (an attempt succeeds iff its data lands within the timeout window).
module tb_sysid_checker;

    localparam logic [31:0] EID  = 32'd0;
    localparam logic [31:0] ETS  = 32'd1489607473;
    localparam int          TOUT = 12;
    localparam int          MAXR = 3;
    localparam int          MAXC = 400;

    typedef struct {
        int          w;
        int          l;
        logic [31:0] data;
    } att_t;

    logic        clock = 1'b0;
    logic        reset, start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, timeout_err;
    logic [31:0] id_value, ts_value;
    logic [1:0]  retry_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   extra_att = 0;
    att_t plan_q[$];

    sysid_checker #(
        .EXPECTED_ID   (EID),
        .EXPECTED_TS   (ETS),
        .TIMEOUT_CYCLES(8'(TOUT)),
        .MAX_RETRIES   (2'(MAXR))
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout_err      (timeout_err),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .retry_count      (retry_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outcome of the planned attempts: retries are shared across both words
    task automatic predict(output bit complete, output int next_word, output bit e_pass,
                           output bit e_terr, output logic [1:0] e_retry,
                           output logic [31:0] e_id, output logic [31:0] e_ts);
        int retries = 0;
        int word    = 0;
        bit failed  = 0;
        e_id = '0;
        e_ts = '0;
        foreach (plan_q[i]) begin
            if (word == 2 || failed) break;
            if (plan_q[i].w + 1 + plan_q[i].l <= TOUT) begin
                if (word == 0) e_id = plan_q[i].data;
                else           e_ts = plan_q[i].data;
                word++;
            end else if (retries < MAXR) begin
                retries++;
            end else begin
                failed = 1;
            end
        end
        complete  = (word == 2) || failed;
        next_word = word;
        e_terr    = failed;
        e_pass    = !failed && (word == 2) && (e_id == EID) && (e_ts == ETS);
        e_retry   = 2'(retries);
    endtask

    task automatic add_att(input int w, input int l, input logic [31:0] data);
        att_t a;
        a.w = w; a.l = l; a.data = data;
        plan_q.push_back(a);
    endtask

    task automatic build_random_plan();
        bit c, p, t;
        int nw;
        logic [1:0] r;
        logic [31:0] i0, t0;
        att_t a;
        plan_q.delete();
        forever begin
            predict(c, nw, p, t, r, i0, t0);
            if (c) break;
            a.w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 14)) : int'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a.l = 200;
                1:       a.l = int'($urandom_range(6, 12));
                default: a.l = int'($urandom_range(0, 4));
            endcase
            if (nw == 0) a.data = ($urandom_range(0, 3) != 0) ? EID : $urandom;
            else case ($urandom_range(0, 3))
                0:       a.data = ETS + 32'd1;
                1:       a.data = $urandom;
                default: a.data = ETS;
            endcase
            plan_q.push_back(a);
        end
    endtask

    // Runs one check against plan_q and compares the result with the model
    task automatic run_check(input string name, input bit poke_busy, input bit poke_done);
        bit c, e_pass, e_terr, seen;
        int nw, cyc;
        logic [1:0] e_retry;
        logic [31:0] e_id, e_ts;
        predict(c, nw, e_pass, e_terr, e_retry, e_id, e_ts);
        extra_att = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check_eq({name, "_busy_after_start"}, 32'(busy), 32'd1);
        cyc  = 1;
        seen = done;
        while (!seen && cyc < MAXC) begin
            start = (poke_busy && busy && $urandom_range(0, 2) == 0);
            @(negedge clock);
            cyc++;
            seen = done;
        end
        start = 1'b0;
        check_eq({name, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({name, "_pass"}, 32'(pass), 32'(e_pass));
        check_eq({name, "_timeout_err"}, 32'(timeout_err), 32'(e_terr));
        check_eq({name, "_retry_count"}, 32'(retry_count), 32'(e_retry));
        check_eq({name, "_id_value"}, id_value, e_id);
        check_eq({name, "_ts_value"}, ts_value, e_ts);
        if (poke_done) start = 1'b1;
        @(negedge clock); start = 1'b0;
        check_eq({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check_eq({name, "_no_restart"}, 32'(busy), 32'd0);
        @(negedge clock);
        check_eq({name, "_idle_hold"}, 32'(busy | avm_read), 32'd0);
        check_eq({name, "_pass_hold"}, 32'(pass), 32'(e_pass));
        check_eq({name, "_plan_used"}, 32'(plan_q.size()), 32'd0);
        check_eq({name, "_extra_attempts"}, 32'(extra_att), 32'd0);
        if (name == "zero_lat") check_eq("zero_lat_latency_ok", 32'(cyc <= 5), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_ctl"}, {26'd0, busy, done, pass, timeout_err, avm_read, avm_address}, 32'd0);
        check_eq({name, "_id"}, id_value, 32'd0);
        check_eq({name, "_ts"}, ts_value, 32'd0);
        check_eq({name, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    // Planned slave: pops one attempt per issued request, injects ignorable strobes
    initial begin
        localparam int P_IDLE = 0, P_REQ = 1, P_DATA = 2;
        int phase = P_IDLE;
        int wl = 0, ll = 0;
        bit prev_stall = 0;
        logic prev_addr = 1'b0;
        logic [1:0] last_retry = '0;
        att_t cur;
        cur.w = 0; cur.l = 0; cur.data = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clock);
            #1;
            if (prev_stall && !done) begin
                check_eq("req_stable_read", 32'(avm_read), 32'd1);
                check_eq("req_stable_addr", 32'(avm_address), 32'(prev_addr));
            end
            avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = $urandom;
            if (reset || !busy) phase = P_IDLE;
            if (!reset && avm_read && (phase != P_REQ || retry_count != last_retry)) begin
                if (plan_q.size() == 0) begin
                    extra_att++;
                    cur.w = 0; cur.l = 0; cur.data = '0;
                end else begin
                    cur = plan_q.pop_front();
                end
                phase = P_REQ;
                wl = cur.w;
            end else if (!avm_read && phase == P_REQ) begin
                phase = P_IDLE;
            end
            if (reset) begin
                phase = P_IDLE;
            end else if (phase == P_REQ) begin
                if (wl > 0) begin
                    avm_waitrequest = 1'b1;
                    wl--;
                    if ($urandom_range(0, 3) == 0) avm_readdatavalid = 1'b1;
                end else if (cur.l == 0) begin
                    avm_readdatavalid = 1'b1; avm_readdata = cur.data; phase = P_IDLE;
                end else begin
                    ll = cur.l; phase = P_DATA;
                end
            end else if (phase == P_DATA) begin
                ll--;
                if (ll == 0) begin
                    avm_readdatavalid = 1'b1; avm_readdata = cur.data; phase = P_IDLE;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                avm_readdatavalid = 1'b1;
            end
            prev_stall = !reset && avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            last_retry = retry_count;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0; start = 1'b0;

        plan_q.delete(); add_att(0, 0, EID); add_att(0, 0, ETS);
        run_check("zero_lat", 0, 0);

        plan_q.delete(); add_att(0, 0, EID); add_att(0, 0, ETS + 32'd1);
        run_check("ts_mismatch", 0, 0);

        plan_q.delete(); add_att(4, 0, EID); add_att(0, 1, ETS);
        run_check("waitreq4", 0, 0);

        plan_q.delete(); add_att(0, 0, EID);
        repeat (4) add_att(0, 200, ETS);
        run_check("ts_never", 0, 0);

        plan_q.delete(); add_att(5, 6, EID); add_att(2, 9, ETS);
        run_check("data_at_timeout", 0, 0);

        plan_q.delete(); add_att(5, 7, EID); add_att(TOUT, 0, EID); add_att(0, 3, EID); add_att(1, 2, ETS);
        run_check("one_past_timeout", 0, 0);

        plan_q.delete(); add_att(2, 3, EID); add_att(1, 1, ETS);
        run_check("pokes", 1, 1);

        // Reset mid-read of the timestamp word, with start held high alongside it
        plan_q.delete(); add_att(0, 0, EID); add_att(0, 200, ETS);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("pre_reset_in_ts_wait", {30'd0, busy, avm_read}, 32'd2);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        plan_q.delete();
        check_all_zero("mid_reset");
        plan_q.delete(); add_att(0, 0, EID); add_att(1, 0, ETS);
        run_check("after_reset", 0, 0);

        for (int i = 0; i < 40; i++) begin
            build_random_plan();
            run_check($sformatf("rand%0d", i), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
